// File: rtl/u_xmit_buf.sv
// Transmit staging buffer: small synchronous FIFO feeding the UART transmitter
// one byte at a time over the xmitH / xmit_dataH / xmit_doneH handshake.
module u_xmit_buf #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_l,
  input  logic                  wr_enH,
  input  logic [7:0]            wr_dataH,
  input  logic                  clr_errH,
  output logic                  fifo_fullH,
  output logic                  fifo_emptyH,
  output logic [DEPTH_LOG2:0]   fifo_countH,
  output logic                  overflowH,
  output logic                  tx_busyH,
  output logic                  xmitH,
  output logic [7:0]            xmit_dataH,
  input  logic                  xmit_doneH
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned GUARD = 8;
  localparam int unsigned GW    = 3;

  typedef enum logic [1:0] {
    B_IDLE    = 2'd0,
    B_SEND    = 2'd1,
    B_WAIT_LO = 2'd2,
    B_WAIT_HI = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;
  logic                  xmit_q, xmit_d;
  logic [7:0]            xdata_q, xdata_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  pop_c;
  logic                  wr_acc_c;

  // Handshake sequencer; a pop only happens on the idle-to-send transition
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pop_c      = 1'b0;
    unique case (state_q)
      B_IDLE: begin
        if (!empty_q && xmit_doneH) begin
          pop_c   = 1'b1;
          state_d = B_SEND;
        end
      end
      B_SEND: begin
        wait_cnt_d = '0;
        state_d    = B_WAIT_LO;
      end
      B_WAIT_LO: begin
        if (!xmit_doneH) begin
          state_d = B_WAIT_HI;
        end else if (wait_cnt_q == GW'(GUARD - 1)) begin
          // transmitter never acknowledged: treat the byte as sent
          state_d = B_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + GW'(1);
        end
      end
      B_WAIT_HI: begin
        if (xmit_doneH) begin
          state_d = B_IDLE;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  // FIFO bookkeeping; a write into a full FIFO is fine if a pop frees a slot
  always_comb begin
    wr_acc_c   = wr_enH && (!full_q || pop_c);
    wr_ptr_d   = wr_acc_c ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_acc_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !wr_acc_c) begin
      count_d = count_q - CW'(1);
    end
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == CW'(0));
    overflow_d = overflow_q;
    if (wr_enH && !wr_acc_c) begin
      overflow_d = 1'b1;
    end else if (clr_errH) begin
      overflow_d = 1'b0;
    end
    xmit_d     = pop_c;
    xdata_d    = pop_c ? mem_q[rd_ptr_q] : xdata_q;
    busy_d     = (state_d != B_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q    <= B_IDLE;
      wait_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      xmit_q     <= 1'b0;
      xdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      xmit_q     <= xmit_d;
      xdata_q    <= xdata_d;
    end
  end

  // Storage array needs no reset; pointers and count define validity
  always_ff @(posedge sys_clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= wr_dataH;
    end
  end

  assign fifo_fullH  = full_q;
  assign fifo_emptyH = empty_q;
  assign fifo_countH = count_q;
  assign overflowH   = overflow_q;
  assign tx_busyH    = busy_q;
  assign xmitH       = xmit_q;
  assign xmit_dataH  = xdata_q;

endmodule

// File: tb/tb_u_xmit_buf.sv
// Bench for u_xmit_buf: directed steps plus random bursts, with a behavioural
// transmitter model and an in-order byte log compared against accepted writes.
module tb_u_xmit_buf;

  logic       sys_clk = 1'b0;
  logic       sys_rst_l = 1'b0;
  logic       wr_enH = 1'b0;
  logic [7:0] wr_dataH = 8'h00;
  logic       clr_errH = 1'b0;
  logic       fifo_fullH, fifo_emptyH, overflowH, tx_busyH, xmitH;
  logic [3:0] fifo_countH;
  logic [7:0] xmit_dataH;
  logic       xmit_doneH;

  u_xmit_buf #(.DEPTH_LOG2(3)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .wr_enH      (wr_enH),
    .wr_dataH    (wr_dataH),
    .clr_errH    (clr_errH),
    .fifo_fullH  (fifo_fullH),
    .fifo_emptyH (fifo_emptyH),
    .fifo_countH (fifo_countH),
    .overflowH   (overflowH),
    .tx_busyH    (tx_busyH),
    .xmitH       (xmitH),
    .xmit_dataH  (xmit_dataH),
    .xmit_doneH  (xmit_doneH)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Transmitter model controls (written only by the stimulus process)
  logic tx_hold_busy = 1'b0;
  logic tx_ignore    = 1'b0;
  int   frame_len    = 4;

  // Transmitter model state (written only by the model process)
  logic       tx_done_m = 1'b1;
  int         tx_phase  = 0;
  int         tx_cnt    = 0;
  logic       xmit_prev = 1'b0;
  logic [7:0] rx_log [0:255];
  int         rx_cyc [0:255];
  int         rx_n      = 0;
  int         bad_req   = 0;
  int         bad_pulse = 0;

  // Expected transmit order (written only by the stimulus process)
  logic [7:0] exp_log [0:255];
  int         exp_n = 0;

  int n_chk  = 0;
  int n_pass = 0;

  assign xmit_doneH = tx_done_m && !tx_hold_busy;

  // Transmitter: samples the request, drops done ~2 cycles later, holds it low for a frame
  always @(negedge sys_clk) begin
    if (!sys_rst_l) begin
      tx_done_m = 1'b1;
      tx_phase  = 0;
      tx_cnt    = 0;
      xmit_prev = 1'b0;
    end else begin
      if (xmitH) begin
        if (xmit_prev) bad_pulse++;
        if (!xmit_doneH) bad_req++;
        rx_log[rx_n] = xmit_dataH;
        rx_cyc[rx_n] = cyc;
        rx_n++;
        if (!tx_ignore) begin
          tx_phase = 1;
          tx_cnt   = 2;
        end
      end else if (tx_phase == 1) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done_m = 1'b0;
          tx_phase  = 2;
          tx_cnt    = frame_len;
        end
      end else if (tx_phase == 2) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done_m = 1'b1;
          tx_phase  = 0;
        end
      end
      xmit_prev = xmitH;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One write in the next cycle; returns 1 time unit after the sampling edge
  task automatic push_byte(input logic [7:0] b, input bit accepted);
    @(negedge sys_clk);
    wr_enH   = 1'b1;
    wr_dataH = b;
    if (accepted) begin
      exp_log[exp_n] = b;
      exp_n++;
    end
    tick();
    wr_enH = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      tick();
      if (!tx_busyH && fifo_emptyH && xmit_doneH) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
    repeat (2) tick();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_xmit"},  32'(xmitH),       32'd0);
    chk({tag, "_data"},  32'(xmit_dataH),  32'h00);
    chk({tag, "_busy"},  32'(tx_busyH),    32'd0);
    chk({tag, "_empty"}, 32'(fifo_emptyH), 32'd1);
    chk({tag, "_full"},  32'(fifo_fullH),  32'd0);
    chk({tag, "_count"}, 32'(fifo_countH), 32'd0);
    chk({tag, "_ovf"},   32'(overflowH),   32'd0);
  endtask

  initial begin
    int rx_mark;
    int len;
    logic [7:0] b;

    // Reset values
    repeat (3) @(negedge sys_clk);
    chk_reset_outs("rst");
    sys_rst_l = 1'b1;
    repeat (2) tick();
    chk_reset_outs("post_rst");

    // Single byte: latency and pulse shape
    push_byte(8'hA5, 1'b1);
    chk("lat_n_empty", 32'(fifo_emptyH), 32'd0);
    chk("lat_n_count", 32'(fifo_countH), 32'd1);
    chk("lat_n_xmit",  32'(xmitH),       32'd0);
    tick();
    chk("lat_n1_xmit",  32'(xmitH),       32'd1);
    chk("lat_n1_data",  32'(xmit_dataH),  32'hA5);
    chk("lat_n1_count", 32'(fifo_countH), 32'd0);
    chk("lat_n1_empty", 32'(fifo_emptyH), 32'd1);
    chk("lat_n1_busy",  32'(tx_busyH),    32'd1);
    tick();
    chk("lat_n2_xmit", 32'(xmitH),    32'd0);
    chk("lat_n2_busy", 32'(tx_busyH), 32'd1);
    wait_idle("single_drain", 100);
    chk("single_data_hold", 32'(xmit_dataH), 32'hA5);

    // Burst of 8 with the transmitter busy fills the FIFO
    @(negedge sys_clk);
    tx_hold_busy = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    chk("burst_full",  32'(fifo_fullH),  32'd1);
    chk("burst_count", 32'(fifo_countH), 32'd8);
    chk("burst_xmit",  32'(xmitH),       32'd0);

    // Write to a full FIFO is dropped and flagged
    push_byte(8'hFF, 1'b0);
    chk("ovf_set",   32'(overflowH),   32'd1);
    chk("ovf_count", 32'(fifo_countH), 32'd8);
    @(negedge sys_clk);
    clr_errH = 1'b1;
    tick();
    clr_errH = 1'b0;
    chk("ovf_clr", 32'(overflowH), 32'd0);

    // Write coinciding with a pop on a full FIFO
    @(negedge sys_clk);
    tx_hold_busy = 1'b0;
    wr_enH   = 1'b1;
    wr_dataH = 8'h09;
    exp_log[exp_n] = 8'h09;
    exp_n++;
    tick();
    wr_enH = 1'b0;
    chk("fullpop_count", 32'(fifo_countH), 32'd8);
    chk("fullpop_full",  32'(fifo_fullH),  32'd1);
    chk("fullpop_ovf",   32'(overflowH),   32'd0);
    chk("fullpop_xmit",  32'(xmitH),       32'd1);
    chk("fullpop_data",  32'(xmit_dataH),  32'h01);
    wait_idle("burst_drain", 400);

    // Transmitter ignores requests: the guard releases each byte
    tx_ignore = 1'b1;
    rx_mark = rx_n;
    push_byte(8'h3C, 1'b1);
    push_byte(8'hC3, 1'b1);
    wait_idle("guard_drain", 100);
    tx_ignore = 1'b0;
    chk("guard_n", 32'(rx_n - rx_mark), 32'd2);
    chk("guard_gap", 32'(rx_cyc[rx_mark + 1] - rx_cyc[rx_mark]), 32'd10);

    // Reset in the middle of a frame with 3 bytes queued
    frame_len = 10;
    rx_mark = rx_n;
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    chk("midrst_count", 32'(fifo_countH), 32'd3);
    repeat (3) tick();
    chk("midrst_busy", 32'(tx_busyH),   32'd1);
    chk("midrst_done", 32'(xmit_doneH), 32'd0);
    sys_rst_l = 1'b0;
    #1;
    chk_reset_outs("midrst");
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    chk("midrst_sent", 32'(rx_n - rx_mark), 32'd1);
    exp_n = rx_n;
    rx_mark = rx_n;
    repeat (20) tick();
    chk("midrst_no_xmit", 32'(rx_n - rx_mark), 32'd0);
    chk("midrst_idle",    32'(tx_busyH),       32'd0);
    frame_len = 4;

    // Random bursts of at most DEPTH bytes, each drained before the next
    for (int r = 0; r < 6; r++) begin
      frame_len = int'($urandom_range(2, 6));
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        repeat ($urandom_range(0, 2)) tick();
        push_byte(b, 1'b1);
      end
      wait_idle("rnd_drain", 600);
      chk("rnd_count", 32'(fifo_countH), 32'd0);
      chk("rnd_ovf",   32'(overflowH),   32'd0);
    end

    // Transmit order and handshake hygiene across the whole run
    chk("total_bytes", 32'(rx_n), 32'(exp_n));
    for (int i = 0; i < exp_n && i < rx_n; i++) begin
      chk($sformatf("order[%0d]", i), 32'(rx_log[i]), 32'(exp_log[i]));
    end
    chk("req_while_busy", 32'(bad_req),   32'd0);
    chk("long_pulse",     32'(bad_pulse), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
